// File: rtl/pipeline_hazard_ctrl.sv
// pipeline_hazard_ctrl: hazard detection, forwarding and stall/flush control for a 5-stage pipeline
module pipeline_hazard_ctrl #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [4:0]  id_rs1,
    input  logic [4:0]  id_rs2,
    input  logic        id_uses_rs1,
    input  logic        id_uses_rs2,
    input  logic [4:0]  ex_rs1,
    input  logic [4:0]  ex_rs2,
    input  logic [4:0]  ex_rd,
    input  logic        ex_mem_read,
    input  logic        ex_redirect,
    input  logic [4:0]  mem_rd,
    input  logic [4:0]  wb_rd,
    input  logic        mem_reg_write,
    input  logic        wb_reg_write,
    input  logic        dmem_req,
    input  logic        dmem_ready,
    output logic        pc_stall,
    output logic        if_id_stall,
    output logic        if_id_flush,
    output logic        id_ex_stall,
    output logic        id_ex_flush,
    output logic        ex_mem_stall,
    output logic        mem_wb_flush,
    output logic [1:0]  fwd_a,
    output logic [1:0]  fwd_b,
    output logic        mem_timeout,
    output logic [15:0] stall_cnt,
    output logic [15:0] flush_cnt
);
    typedef enum logic [1:0] {ST_RUN, ST_WAIT, ST_TIMEOUT} state_t;

    state_t      state_q, state_d;
    logic [7:0]  wait_cnt_q, wait_cnt_d;
    logic        mem_timeout_q, mem_timeout_d;
    logic [15:0] stall_cnt_q, stall_cnt_d;
    logic [15:0] flush_cnt_q, flush_cnt_d;
    logic        load_use, freeze;

    assign load_use = ex_mem_read && (ex_rd != 5'd0) &&
                      ((id_uses_rs1 && id_rs1 == ex_rd) || (id_uses_rs2 && id_rs2 == ex_rd));
    assign freeze   = (dmem_req && !dmem_ready) || (state_q == ST_TIMEOUT);

    // Operand forwarding: the younger MEM result wins over WB
    always_comb begin
        fwd_a = (mem_reg_write && mem_rd != 5'd0 && mem_rd == ex_rs1) ? 2'b10 :
                (wb_reg_write && wb_rd != 5'd0 && wb_rd == ex_rs1)    ? 2'b01 : 2'b00;
        fwd_b = (mem_reg_write && mem_rd != 5'd0 && mem_rd == ex_rs2) ? 2'b10 :
                (wb_reg_write && wb_rd != 5'd0 && wb_rd == ex_rs2)    ? 2'b01 : 2'b00;
    end

    // Pipeline control priority: freeze, then redirect, then load-use bubble
    always_comb begin
        pc_stall     = freeze || (!ex_redirect && load_use);
        if_id_stall  = freeze || (!ex_redirect && load_use);
        if_id_flush  = !freeze && ex_redirect;
        id_ex_stall  = freeze;
        id_ex_flush  = !freeze && (ex_redirect || load_use);
        ex_mem_stall = freeze;
        mem_wb_flush = freeze;
    end

    // Memory-wait FSM, wait counter, sticky timeout and saturating event counters
    always_comb begin
        state_d       = state_q;
        wait_cnt_d    = wait_cnt_q;
        mem_timeout_d = mem_timeout_q;
        case (state_q)
            ST_RUN: begin
                if (dmem_req && !dmem_ready) begin
                    state_d    = ST_WAIT;
                    wait_cnt_d = 8'd1;
                end
            end
            ST_WAIT: begin
                if (dmem_ready || !dmem_req) begin
                    state_d    = ST_RUN;
                    wait_cnt_d = 8'd0;
                end else if (wait_cnt_q == 8'(TIMEOUT)) begin
                    state_d       = ST_TIMEOUT;
                    wait_cnt_d    = 8'd0;
                    mem_timeout_d = 1'b1;
                end else begin
                    wait_cnt_d = wait_cnt_q + 8'd1;
                end
            end
            default: state_d = ST_TIMEOUT;
        endcase
        stall_cnt_d = ((freeze || (load_use && !ex_redirect)) && stall_cnt_q != 16'hFFFF) ?
                      stall_cnt_q + 16'd1 : stall_cnt_q;
        flush_cnt_d = (ex_redirect && !freeze && flush_cnt_q != 16'hFFFF) ?
                      flush_cnt_q + 16'd1 : flush_cnt_q;
    end

    // State registers with asynchronous reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= ST_RUN;
            wait_cnt_q    <= 8'd0;
            mem_timeout_q <= 1'b0;
            stall_cnt_q   <= 16'd0;
            flush_cnt_q   <= 16'd0;
        end else begin
            state_q       <= state_d;
            wait_cnt_q    <= wait_cnt_d;
            mem_timeout_q <= mem_timeout_d;
            stall_cnt_q   <= stall_cnt_d;
            flush_cnt_q   <= flush_cnt_d;
        end
    end

    assign mem_timeout = mem_timeout_q;
    assign stall_cnt   = stall_cnt_q;
    assign flush_cnt   = flush_cnt_q;
endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// tb_pipeline_hazard_ctrl: directed vector table plus multi-cycle sequences for the hazard controller
module tb_pipeline_hazard_ctrl;
    logic clk = 1'b0;
    logic rst, rst3;
    logic [4:0] id_rs1, id_rs2, ex_rs1, ex_rs2, ex_rd, mem_rd, wb_rd;
    logic id_uses_rs1, id_uses_rs2, ex_mem_read, ex_redirect;
    logic mem_reg_write, wb_reg_write, dmem_req, dmem_ready;

    logic pc_stall, if_id_stall, if_id_flush, id_ex_stall, id_ex_flush, ex_mem_stall, mem_wb_flush;
    logic [1:0] fwd_a, fwd_b;
    logic mem_timeout;
    logic [15:0] stall_cnt, flush_cnt;

    logic pc_stall3, if_id_stall3, if_id_flush3, id_ex_stall3, id_ex_flush3, ex_mem_stall3, mem_wb_flush3;
    logic [1:0] fwd_a3, fwd_b3;
    logic mem_timeout3;
    logic [15:0] stall_cnt3, flush_cnt3;

    logic [6:0] ctl, ctl3;
    assign ctl  = {pc_stall, if_id_stall, if_id_flush, id_ex_stall, id_ex_flush, ex_mem_stall, mem_wb_flush};
    assign ctl3 = {pc_stall3, if_id_stall3, if_id_flush3, id_ex_stall3, id_ex_flush3, ex_mem_stall3, mem_wb_flush3};

    localparam logic [6:0] NONE   = 7'b0000000;
    localparam logic [6:0] FREEZE = 7'b1101011;
    localparam logic [6:0] REDIR  = 7'b0010100;
    localparam logic [6:0] LUSE   = 7'b1100100;

    always #5 clk = ~clk;

    pipeline_hazard_ctrl dut (
        .clk(clk), .rst(rst), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2),
        .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd), .ex_mem_read(ex_mem_read),
        .ex_redirect(ex_redirect), .mem_rd(mem_rd), .wb_rd(wb_rd),
        .mem_reg_write(mem_reg_write), .wb_reg_write(wb_reg_write),
        .dmem_req(dmem_req), .dmem_ready(dmem_ready),
        .pc_stall(pc_stall), .if_id_stall(if_id_stall), .if_id_flush(if_id_flush),
        .id_ex_stall(id_ex_stall), .id_ex_flush(id_ex_flush), .ex_mem_stall(ex_mem_stall),
        .mem_wb_flush(mem_wb_flush), .fwd_a(fwd_a), .fwd_b(fwd_b),
        .mem_timeout(mem_timeout), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    pipeline_hazard_ctrl #(.TIMEOUT(3)) dut3 (
        .clk(clk), .rst(rst3), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2),
        .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd), .ex_mem_read(ex_mem_read),
        .ex_redirect(ex_redirect), .mem_rd(mem_rd), .wb_rd(wb_rd),
        .mem_reg_write(mem_reg_write), .wb_reg_write(wb_reg_write),
        .dmem_req(dmem_req), .dmem_ready(dmem_ready),
        .pc_stall(pc_stall3), .if_id_stall(if_id_stall3), .if_id_flush(if_id_flush3),
        .id_ex_stall(id_ex_stall3), .id_ex_flush(id_ex_flush3), .ex_mem_stall(ex_mem_stall3),
        .mem_wb_flush(mem_wb_flush3), .fwd_a(fwd_a3), .fwd_b(fwd_b3),
        .mem_timeout(mem_timeout3), .stall_cnt(stall_cnt3), .flush_cnt(flush_cnt3)
    );

    typedef struct packed {
        logic [4:0] id_rs1, id_rs2;
        logic       u1, u2;
        logic [4:0] ex_rs1, ex_rs2, ex_rd;
        logic       mr, redir;
        logic [4:0] mem_rd, wb_rd;
        logic       mw, ww, req, rdy;
        logic [6:0] ctl;
        logic [1:0] fa, fb;
    } vec_t;

    vec_t vecs [12];
    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic idle();
        {id_rs1, id_rs2, ex_rs1, ex_rs2, ex_rd, mem_rd, wb_rd} = '0;
        {id_uses_rs1, id_uses_rs2, ex_mem_read, ex_redirect} = '0;
        {mem_reg_write, wb_reg_write, dmem_req, dmem_ready} = '0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        vecs[0]  = '{5'd0, 5'd0, 1'b0, 1'b0, 5'd5, 5'd0, 5'd0, 1'b0, 1'b0, 5'd5, 5'd5, 1'b1, 1'b1, 1'b0, 1'b0, NONE,  2'b10, 2'b00};
        vecs[1]  = '{5'd0, 5'd0, 1'b0, 1'b0, 5'd5, 5'd0, 5'd0, 1'b0, 1'b0, 5'd5, 5'd5, 1'b0, 1'b1, 1'b0, 1'b0, NONE,  2'b01, 2'b00};
        vecs[2]  = '{5'd0, 5'd0, 1'b0, 1'b0, 5'd5, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 5'd0, 1'b1, 1'b1, 1'b0, 1'b0, NONE,  2'b00, 2'b00};
        vecs[3]  = '{5'd0, 5'd0, 1'b0, 1'b0, 5'd1, 5'd7, 5'd0, 1'b0, 1'b0, 5'd6, 5'd7, 1'b1, 1'b1, 1'b0, 1'b0, NONE,  2'b00, 2'b01};
        vecs[4]  = '{5'd0, 5'd0, 1'b0, 1'b0, 5'd1, 5'd9, 5'd0, 1'b0, 1'b0, 5'd9, 5'd9, 1'b1, 1'b1, 1'b0, 1'b0, NONE,  2'b00, 2'b10};
        vecs[5]  = '{5'd0, 5'd3, 1'b0, 1'b1, 5'd0, 5'd0, 5'd3, 1'b1, 1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, LUSE,  2'b00, 2'b00};
        vecs[6]  = '{5'd3, 5'd0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd3, 1'b1, 1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, NONE,  2'b00, 2'b00};
        vecs[7]  = '{5'd0, 5'd0, 1'b1, 1'b1, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, NONE,  2'b00, 2'b00};
        vecs[8]  = '{5'd3, 5'd0, 1'b1, 1'b0, 5'd0, 5'd0, 5'd3, 1'b0, 1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, NONE,  2'b00, 2'b00};
        vecs[9]  = '{5'd0, 5'd3, 1'b0, 1'b1, 5'd0, 5'd0, 5'd3, 1'b1, 1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, REDIR, 2'b00, 2'b00};
        vecs[10] = '{5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, REDIR, 2'b00, 2'b00};
        vecs[11] = '{5'd3, 5'd0, 1'b1, 1'b0, 5'd0, 5'd0, 5'd3, 1'b1, 1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1, LUSE,  2'b00, 2'b00};

        idle();
        rst = 1'b1;
        rst3 = 1'b1;
        tick();
        chk("reset_stall_cnt", stall_cnt, 16'd0);
        chk("reset_flush_cnt", flush_cnt, 16'd0);
        chk("reset_mem_timeout", {15'd0, mem_timeout}, 16'd0);
        chk("reset_ctl", {9'd0, ctl}, {9'd0, NONE});
        rst = 1'b0;
        rst3 = 1'b0;

        for (int i = 0; i < 12; i++) begin
            {id_rs1, id_rs2, id_uses_rs1, id_uses_rs2, ex_rs1, ex_rs2, ex_rd, ex_mem_read, ex_redirect,
             mem_rd, wb_rd, mem_reg_write, wb_reg_write, dmem_req, dmem_ready} =
                {vecs[i].id_rs1, vecs[i].id_rs2, vecs[i].u1, vecs[i].u2, vecs[i].ex_rs1, vecs[i].ex_rs2,
                 vecs[i].ex_rd, vecs[i].mr, vecs[i].redir, vecs[i].mem_rd, vecs[i].wb_rd,
                 vecs[i].mw, vecs[i].ww, vecs[i].req, vecs[i].rdy};
            #1;
            chk($sformatf("vec%0d_ctl", i), {9'd0, ctl}, {9'd0, vecs[i].ctl});
            chk($sformatf("vec%0d_fwd", i), {12'd0, fwd_a, fwd_b}, {12'd0, vecs[i].fa, vecs[i].fb});
        end

        idle();
        rst = 1'b1;
        #1;
        chk("rerst_stall_cnt", stall_cnt, 16'd0);
        rst = 1'b0;
        tick();

        ex_mem_read = 1'b1; ex_rd = 5'd3; id_rs2 = 5'd3; id_uses_rs2 = 1'b1;
        #1;
        chk("lu_ctl", {9'd0, ctl}, {9'd0, LUSE});
        tick();
        idle();
        #1;
        chk("lu_after_ctl", {9'd0, ctl}, {9'd0, NONE});
        chk("lu_stall_cnt", stall_cnt, 16'd1);

        ex_mem_read = 1'b1; ex_rd = 5'd3; id_rs2 = 5'd3; id_uses_rs2 = 1'b1; ex_redirect = 1'b1;
        #1;
        chk("redir_lu_ctl", {9'd0, ctl}, {9'd0, REDIR});
        tick();
        idle();
        chk("redir_lu_flush_cnt", flush_cnt, 16'd1);
        chk("redir_lu_stall_cnt", stall_cnt, 16'd1);

        dmem_req = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            chk($sformatf("memwait%0d_ctl", i), {9'd0, ctl}, {9'd0, FREEZE});
            tick();
        end
        dmem_ready = 1'b1;
        #1;
        chk("memwait_release_ctl", {9'd0, ctl}, {9'd0, NONE});
        chk("memwait_stall_cnt", stall_cnt, 16'd5);
        tick();
        idle();
        chk("memwait_after_stall_cnt", stall_cnt, 16'd5);
        chk("memwait_no_timeout", {15'd0, mem_timeout}, 16'd0);

        dmem_req = 1'b1; ex_redirect = 1'b1;
        #1;
        chk("wait_redir_frozen_ctl", {9'd0, ctl}, {9'd0, FREEZE});
        tick();
        dmem_ready = 1'b1;
        #1;
        chk("ready_redir_ctl", {9'd0, ctl}, {9'd0, REDIR});
        tick();
        idle();
        chk("ready_redir_flush_cnt", flush_cnt, 16'd2);
        chk("ready_redir_stall_cnt", stall_cnt, 16'd6);

        rst3 = 1'b1;
        #1;
        rst3 = 1'b0;
        dmem_req = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            chk($sformatf("to%0d_ctl", i), {9'd0, ctl3}, {9'd0, FREEZE});
            chk($sformatf("to%0d_mem_timeout", i), {15'd0, mem_timeout3}, 16'd0);
            tick();
        end
        chk("to_mem_timeout", {15'd0, mem_timeout3}, 16'd1);
        dmem_req = 1'b0;
        #1;
        chk("to_req_drop_ctl", {9'd0, ctl3}, {9'd0, FREEZE});
        tick();
        chk("to_stall_cnt", stall_cnt3, 16'd5);
        dmem_req = 1'b1; dmem_ready = 1'b1;
        #1;
        chk("to_ready_ctl", {9'd0, ctl3}, {9'd0, FREEZE});
        tick();
        chk("to_sticky", {15'd0, mem_timeout3}, 16'd1);
        idle();
        rst3 = 1'b1;
        #1;
        chk("to_rst_mem_timeout", {15'd0, mem_timeout3}, 16'd0);
        chk("to_rst_stall_cnt", stall_cnt3, 16'd0);
        chk("to_rst_ctl", {9'd0, ctl3}, {9'd0, NONE});
        rst3 = 1'b0;

        dmem_req = 1'b1;
        repeat (65534) tick();
        chk("sat_fffe", stall_cnt3, 16'hFFFE);
        tick();
        chk("sat_ffff", stall_cnt3, 16'hFFFF);
        repeat (3) tick();
        chk("sat_hold", stall_cnt3, 16'hFFFF);
        idle();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
